// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one mem_system (cache + banked
//               memory) between the instruction-fetch and data-memory ports.
//               Latches the winning request, holds the memory command stable
//               until Done, returns registered data with a one-cycle done
//               pulse, counts per-port cache hits and flags errors/timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  // instruction port
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  output logic [15:0] i_dataout,
  output logic        i_done,
  output logic        i_stall,
  // data port
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_datain,
  output logic [15:0] d_dataout,
  output logic        d_done,
  output logic        d_stall,
  // mem_system side
  output logic [15:0] m_addr,
  output logic [15:0] m_datain,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [15:0] m_dataout,
  input  logic        m_done,
  input  logic        m_cachehit,
  input  logic        m_err,
  // status
  output logic        err,
  output logic [15:0] i_hits,
  output logic [15:0] d_hits
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_last_grant_d;  // 1: data port won the most recent grant
  logic [15:0] r_lat_addr;
  logic [15:0] r_lat_datain;
  logic        r_lat_rd;
  logic        r_lat_wr;
  logic [7:0]  r_tcnt;

  logic        w_busy;
  logic        w_i_req;
  logic        w_d_req;
  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_timeout;
  logic        w_fail;
  logic        w_exit;
  logic [15:0] w_resp_data;

  assign w_busy  = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_i_req = i_rd;
  assign w_d_req = d_rd | d_wr;

  // Data wins when it is alone, or on a tie when instruction had the last turn.
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_grant_d);
  assign w_grant_i = w_i_req & ~w_grant_d;

  assign w_timeout = (r_tcnt == c_timeout_last);
  // A normal Done takes priority over a simultaneous timeout expiry.
  assign w_fail    = m_err | (~m_done & w_timeout);
  assign w_exit    = m_err | m_done | w_timeout;
  // Writes and failed transactions return zero data.
  assign w_resp_data = (w_fail || r_lat_wr) ? 16'h0000 : m_dataout;

  // Memory command comes only from latched state; Rd/Wr drop in the Done
  // cycle so mem_system returns to idle instead of chaining another access.
  assign m_addr   = r_lat_addr;
  assign m_datain = r_lat_datain;
  assign m_rd     = w_busy & r_lat_rd & ~m_done;
  assign m_wr     = w_busy & r_lat_wr & ~m_done;

  // Stalls are forced low while reset is held so every output reads zero.
  assign i_stall = rst & i_rd & ~i_done;
  assign d_stall = rst & (d_rd | d_wr) & ~d_done;

  // Arbitration FSM, request latching, response, counters and error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_last_grant_d <= 1'b1;
      r_lat_addr     <= 16'h0000;
      r_lat_datain   <= 16'h0000;
      r_lat_rd       <= 1'b0;
      r_lat_wr       <= 1'b0;
      r_tcnt         <= 8'd0;
      i_done         <= 1'b0;
      d_done         <= 1'b0;
      i_dataout      <= 16'h0000;
      d_dataout      <= 16'h0000;
      err            <= 1'b0;
      i_hits         <= 16'h0000;
      d_hits         <= 16'h0000;
    end else begin
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_dataout <= 16'h0000;
      d_dataout <= 16'h0000;
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_last_grant_d <= 1'b0;
            r_lat_addr     <= i_addr;
            r_lat_datain   <= 16'h0000;
            r_lat_rd       <= 1'b1;
            r_lat_wr       <= 1'b0;
            r_tcnt         <= 8'd0;
            r_state        <= BUSY_I;
          end else if (w_grant_d) begin
            r_last_grant_d <= 1'b1;
            if (d_rd && d_wr) begin
              // Read and write together is illegal: answer without issuing.
              err       <= 1'b1;
              r_lat_rd  <= 1'b0;
              r_lat_wr  <= 1'b0;
              d_done    <= 1'b1;
              r_state   <= RESP;
            end else begin
              r_lat_addr   <= d_addr;
              r_lat_datain <= d_datain;
              r_lat_rd     <= d_rd;
              r_lat_wr     <= d_wr;
              r_tcnt       <= 8'd0;
              r_state      <= BUSY_D;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (w_exit) begin
            r_state <= RESP;
            if (w_fail) begin
              err <= 1'b1;
            end
            if (r_state == BUSY_D) begin
              d_done    <= 1'b1;
              d_dataout <= w_resp_data;
            end else begin
              i_done    <= 1'b1;
              i_dataout <= w_resp_data;
            end
            if (!w_fail && m_cachehit) begin
              if (r_state == BUSY_D) begin
                if (d_hits != 16'hFFFF) d_hits <= d_hits + 16'd1;
              end else begin
                if (i_hits != 16'hFFFF) i_hits <= i_hits + 16'd1;
              end
            end
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed scoreboard bench for mem_port_arbiter. Stimulus pushes
//               the expected {port, data} of each completion; a monitor pops
//               and compares whenever a done pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_rd = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic [15:0] i_dataout;
  logic        i_done;
  logic        i_stall;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] d_datain = 16'h0000;
  logic [15:0] d_dataout;
  logic        d_done;
  logic        d_stall;
  logic [15:0] m_addr;
  logic [15:0] m_datain;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_dataout = 16'h0000;
  logic        m_done = 1'b0;
  logic        m_cachehit = 1'b0;
  logic        m_err = 1'b0;
  logic        err;
  logic [15:0] i_hits;
  logic [15:0] d_hits;

  int total = 0;
  int bad   = 0;

  // expected completion: {owner is data port, response data}
  logic [16:0] exp_q[$];

  mem_port_arbiter #(.TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rd       (i_rd),
    .i_addr     (i_addr),
    .i_dataout  (i_dataout),
    .i_done     (i_done),
    .i_stall    (i_stall),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .d_addr     (d_addr),
    .d_datain   (d_datain),
    .d_dataout  (d_dataout),
    .d_done     (d_done),
    .d_stall    (d_stall),
    .m_addr     (m_addr),
    .m_datain   (m_datain),
    .m_rd       (m_rd),
    .m_wr       (m_wr),
    .m_dataout  (m_dataout),
    .m_done     (m_done),
    .m_cachehit (m_cachehit),
    .m_err      (m_err),
    .err        (err),
    .i_hits     (i_hits),
    .d_hits     (d_hits)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && (i_done || d_done)) begin
      if (i_done && d_done) begin
        check("both_done", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_done", {15'd0, d_done, (d_done ? d_dataout : i_dataout)}, 32'h1FFFF);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("resp_port_data", {15'd0, d_done, (d_done ? d_dataout : i_dataout)}, {15'd0, e});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Returns at the first negedge where the arbiter issues Rd or Wr.
  task automatic wait_mreq();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_rd || m_wr) begin
        seen = 1'b1;
        break;
      end
    end
    check("mreq_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_done(input logic port_d);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((port_d ? d_done : i_done) == 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
  endtask

  // mem_system model: answers the next command after lat cycles.
  task automatic serve(input int lat, input logic hit, input logic [15:0] rdata,
                       input logic [15:0] eaddr, input logic ewr, input logic [15:0] edin);
    wait_mreq();
    check("m_addr", {16'd0, m_addr}, {16'd0, eaddr});
    check("m_wr_op", {31'd0, m_wr}, {31'd0, ewr});
    check("m_rd_op", {31'd0, m_rd}, {31'd0, ~ewr});
    if (ewr) check("m_datain", {16'd0, m_datain}, {16'd0, edin});
    repeat (lat) @(posedge clk);
    #1;
    m_done = 1'b1; m_cachehit = hit; m_dataout = rdata;
    @(negedge clk);
    check("rdwr_low_in_done", {30'd0, m_rd, m_wr}, 32'd0);
    check("m_addr_held", {16'd0, m_addr}, {16'd0, eaddr});
    @(posedge clk); #1;
    m_done = 1'b0; m_cachehit = 1'b0; m_dataout = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int cnt;
    logic issued;

    // ---- reset with a pending instruction request, then a 2-cycle hit ----
    i_rd = 1'b1; i_addr = 16'h0040;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_done_stall", {28'd0, i_done, d_done, i_stall, d_stall}, 32'd0);
    check("reset_mem_cmd", {30'd0, m_rd, m_wr}, 32'd0);
    check("reset_status", {err, i_hits, d_hits[14:0]}, 32'd0);
    check("reset_data", {i_dataout, d_dataout}, 32'd0);
    exp_q.push_back({1'b0, 16'hBEEF});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("no_rd_in_grant_cycle", {31'd0, m_rd}, 32'd0);
    @(negedge clk);
    check("rd_cycle_after_grant", {15'd0, m_rd, m_addr}, {15'd0, 1'b1, 16'h0040});
    @(posedge clk);
    @(posedge clk); #1;
    m_done = 1'b1; m_cachehit = 1'b1; m_dataout = 16'hBEEF;
    @(negedge clk);
    check("rd_low_in_done", {31'd0, m_rd}, 32'd0);
    @(posedge clk); #1;
    m_done = 1'b0; m_cachehit = 1'b0; m_dataout = 16'h0000;
    @(negedge clk);
    check("i_done_latency", {31'd0, i_done}, 32'd1);
    check("i_hits_one", {16'd0, i_hits}, 32'd1);
    i_rd = 1'b0;

    // ---- round robin with both ports requesting continuously ----
    do_reset();
    i_addr = 16'h0010; d_addr = 16'h0100; d_datain = 16'h1234;
    exp_q.push_back({1'b0, 16'hA001});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b0, 16'hA002});
    exp_q.push_back({1'b1, 16'h0000});
    i_rd = 1'b1; d_wr = 1'b1;
    serve(2, 1'b0, 16'hA001, 16'h0010, 1'b0, 16'h0000);
    serve(3, 1'b1, 16'h5555, 16'h0100, 1'b1, 16'h1234);
    serve(2, 1'b1, 16'hA002, 16'h0010, 1'b0, 16'h0000);
    serve(2, 1'b1, 16'h5555, 16'h0100, 1'b1, 16'h1234);
    i_rd = 1'b0; d_wr = 1'b0;
    @(negedge clk);
    check("rr_hits", {i_hits, d_hits}, {16'd1, 16'd2});
    check("rr_no_err", {31'd0, err}, 32'd0);

    // ---- illegal read+write on the data port ----
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({1'b1, 16'h0000});
    d_rd = 1'b1; d_wr = 1'b1;
    issued = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_rd || m_wr) issued = 1'b1;
      if (d_done) break;
    end
    check("illegal_no_issue", {31'd0, issued}, 32'd0);
    check("illegal_err_done", {30'd0, err, d_done}, 32'd3);
    d_rd = 1'b0; d_wr = 1'b0;

    // ---- reset in the middle of a data write ----
    repeat (2) @(posedge clk);
    #1;
    d_wr = 1'b1; d_addr = 16'h0500; d_datain = 16'h9999;
    wait_mreq();
    @(posedge clk); #1;
    rst = 1'b0; d_wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_mem_cmd", {30'd0, m_wr, d_done}, 32'd0);
    check("rst_mid_status", {err, i_hits, d_hits[14:0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // ---- data read miss, address changes mid-transaction ----
    do_reset();
    exp_q.push_back({1'b1, 16'h7777});
    d_rd = 1'b1; d_addr = 16'h0200;
    @(posedge clk); #1;
    d_addr = 16'hFFFF;
    serve(20, 1'b0, 16'h7777, 16'h0200, 1'b0, 16'h0000);
    @(negedge clk);
    check("miss_done_timing", {30'd0, d_done, i_done}, 32'd2);
    check("miss_no_hit", {16'd0, d_hits}, 32'd0);
    d_rd = 1'b0;

    // ---- timeout when m_done never comes ----
    do_reset();
    exp_q.push_back({1'b0, 16'h0000});
    i_rd = 1'b1; i_addr = 16'h0300;
    wait_mreq();
    cnt = 0;
    while (m_rd && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_busy_cycles", cnt, 32'd64);
    check("timeout_err_done", {30'd0, err, i_done}, 32'd3);
    i_rd = 1'b0;

    // ---- m_err during an instruction fetch ----
    do_reset();
    exp_q.push_back({1'b0, 16'h0000});
    i_rd = 1'b1; i_addr = 16'h0400;
    wait_mreq();
    @(posedge clk); #1;
    m_err = 1'b1; m_dataout = 16'hDEAD;
    @(negedge clk);
    check("no_err_before_edge", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    m_err = 1'b0; m_dataout = 16'h0000;
    wait_done(1'b0);
    check("merr_err", {31'd0, err}, 32'd1);
    i_rd = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
